// File: rtl/pwm_tx_sr_if.sv
// pwm_tx_sr_if
//   Groups the control inputs and gate-drive outputs of pwm_tx_sr so the
//   controller side and the transmitter share one bundle.
//   master : drives enable, pwm_chg, act_ctl, off_div, pre_delay, post_delay,
//            fault, fault_clr; observes the gate outputs and status flags.
//   slave  : the transmitter; consumes the controls and drives pwm_out,
//            secondary_out, period_start, ramp_done, fault_flag.
interface pwm_tx_sr_if #(
  parameter int CNT_WIDTH = 16
);
  logic                 enable;
  logic                 pwm_chg;
  logic                 act_ctl;
  logic [CNT_WIDTH-1:0] off_div;
  logic [CNT_WIDTH-1:0] pre_delay;
  logic [CNT_WIDTH-1:0] post_delay;
  logic                 fault;
  logic                 fault_clr;
  logic                 pwm_out;
  logic                 secondary_out;
  logic                 period_start;
  logic                 ramp_done;
  logic                 fault_flag;

  modport master (
    output enable, pwm_chg, act_ctl, off_div, pre_delay, post_delay,
           fault, fault_clr,
    input  pwm_out, secondary_out, period_start, ramp_done, fault_flag
  );

  modport slave (
    input  enable, pwm_chg, act_ctl, off_div, pre_delay, post_delay,
           fault, fault_clr,
    output pwm_out, secondary_out, period_start, ramp_done, fault_flag
  );
endinterface

// File: rtl/pwm_tx_sr.sv
// pwm_tx_sr
//   Primary PWM transmitter with a dead-time-windowed synchronous-rectifier
//   secondary drive. Each period is ON_DIV cycles of primary drive followed by
//   off_eff cycles of OFF, during which the secondary is driven inside a
//   window trimmed by pre/post delays. New timing sets are shadowed and only
//   take effect at a period boundary; off-time soft-starts from START_OFF_DIV
//   and ramps down by at most RAMP_STEP per period.
// Ports:
//   clk    : system clock
//   n_rst  : asynchronous active-low reset
//   bus    : pwm_tx_sr_if.slave (controls in, gate drives and flags out)
module pwm_tx_sr #(
  parameter int CNT_WIDTH     = 16,
  parameter int ON_DIV        = 20,
  parameter int START_OFF_DIV = 100,
  parameter int RAMP_STEP     = 10
) (
  input logic         clk,
  input logic         n_rst,
  pwm_tx_sr_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, ON, OFF, FAULT} state_t;

  localparam logic [CNT_WIDTH-1:0] ON_LAST   = CNT_WIDTH'(ON_DIV - 1);
  localparam logic [CNT_WIDTH-1:0] START_OFF = CNT_WIDTH'(START_OFF_DIV);
  localparam logic [CNT_WIDTH-1:0] STEP      = CNT_WIDTH'(RAMP_STEP);
  localparam logic [CNT_WIDTH-1:0] ONE       = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] offEff_q, offEff_d;
  logic [CNT_WIDTH-1:0] offAct_q, offAct_d;
  logic [CNT_WIDTH-1:0] preAct_q, preAct_d;
  logic [CNT_WIDTH-1:0] postAct_q, postAct_d;
  logic [CNT_WIDTH-1:0] offPend_q, offPend_d;
  logic [CNT_WIDTH-1:0] prePend_q, prePend_d;
  logic [CNT_WIDTH-1:0] postPend_q, postPend_d;
  logic                 pendValid_q, pendValid_d;
  logic                 pwmOut_q, pwmOut_d;
  logic                 secOut_q, secOut_d;
  logic                 periodStart_q, periodStart_d;
  logic                 rampDone_q, rampDone_d;
  logic                 faultFlag_q, faultFlag_d;

  logic [CNT_WIDTH-1:0] offLen;
  logic [CNT_WIDTH-1:0] rampGap;
  logic [CNT_WIDTH:0]   cntExt;
  logic                 boundary;

  // A zero off-time still needs one OFF cycle so the primary gets released.
  assign offLen = (offEff_q == '0) ? ONE : offEff_q;

  // Next-state: fault dominates, then FAULT only exits on a clean clear,
  // then losing enable parks in IDLE, otherwise run the ON/OFF sequence.
  always_comb begin
    state_d = state_q;
    if (bus.fault) begin
      state_d = FAULT;
    end else if (state_q == FAULT) begin
      if (bus.fault_clr) state_d = IDLE;
    end else if (!bus.enable) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    state_d = ON;
        ON:      if (cnt_q == ON_LAST) state_d = OFF;
        OFF:     if (cnt_q == offLen - ONE) state_d = ON;
        default: state_d = IDLE;
      endcase
    end
  end

  // Phase counter restarts on every state change and saturates instead of
  // wrapping so an idle/fault dwell can never alias into a phase limit.
  always_comb begin
    cnt_d = cnt_q;
    if (state_d != state_q)  cnt_d = '0;
    else if (cnt_q != CNT_MAX) cnt_d = cnt_q + ONE;
  end

  assign boundary = (state_d == ON) && (state_q != ON);

  // Shadow registers: the active set only moves at a boundary and takes the
  // pending set as it stood before this edge, so a capture landing on the
  // boundary edge itself waits for the following period.
  always_comb begin
    offAct_d    = offAct_q;
    preAct_d    = preAct_q;
    postAct_d   = postAct_q;
    offPend_d   = offPend_q;
    prePend_d   = prePend_q;
    postPend_d  = postPend_q;
    pendValid_d = pendValid_q;
    if (boundary && pendValid_q) begin
      offAct_d    = offPend_q;
      preAct_d    = prePend_q;
      postAct_d   = postPend_q;
      pendValid_d = 1'b0;
    end
    if (bus.pwm_chg) begin
      offPend_d   = bus.off_div;
      prePend_d   = bus.pre_delay;
      postPend_d  = bus.post_delay;
      pendValid_d = 1'b1;
    end
  end

  // Off-time soft start: restart from START_OFF_DIV when leaving IDLE or when
  // held by act_ctl; shrink toward the target by at most STEP per period;
  // growth toward a longer off-time is taken at once since that is safe.
  always_comb begin
    offEff_d = offEff_q;
    rampGap  = offEff_q - offAct_d;
    if (boundary) begin
      if (state_q == IDLE || bus.act_ctl) begin
        offEff_d = START_OFF;
      end else if (offEff_q > offAct_d) begin
        offEff_d = offEff_q - ((rampGap > STEP) ? STEP : rampGap);
      end else begin
        offEff_d = offAct_d;
      end
    end
  end

  // Outputs are registered from the next state/count. The secondary window
  // is pre <= k < off_eff - post, evaluated one bit wider so the sum
  // k + post cannot overflow and an oversized dead time yields no window.
  always_comb begin
    cntExt        = {1'b0, cnt_d};
    pwmOut_d      = (state_d == ON);
    secOut_d      = (state_d == OFF)
                    && (cntExt >= {1'b0, preAct_q})
                    && ((cntExt + {1'b0, postAct_q}) < {1'b0, offEff_q});
    periodStart_d = boundary;
    faultFlag_d   = (state_d == FAULT);
    rampDone_d    = (offEff_d == offAct_d) && !bus.act_ctl;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      offEff_q      <= START_OFF;
      offAct_q      <= '0;
      preAct_q      <= '0;
      postAct_q     <= '0;
      offPend_q     <= '0;
      prePend_q     <= '0;
      postPend_q    <= '0;
      pendValid_q   <= 1'b0;
      pwmOut_q      <= 1'b0;
      secOut_q      <= 1'b0;
      periodStart_q <= 1'b0;
      rampDone_q    <= 1'b0;
      faultFlag_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      offEff_q      <= offEff_d;
      offAct_q      <= offAct_d;
      preAct_q      <= preAct_d;
      postAct_q     <= postAct_d;
      offPend_q     <= offPend_d;
      prePend_q     <= prePend_d;
      postPend_q    <= postPend_d;
      pendValid_q   <= pendValid_d;
      pwmOut_q      <= pwmOut_d;
      secOut_q      <= secOut_d;
      periodStart_q <= periodStart_d;
      rampDone_q    <= rampDone_d;
      faultFlag_q   <= faultFlag_d;
    end
  end

  assign bus.pwm_out       = pwmOut_q;
  assign bus.secondary_out = secOut_q;
  assign bus.period_start  = periodStart_q;
  assign bus.ramp_done     = rampDone_q;
  assign bus.fault_flag    = faultFlag_q;

endmodule

// File: tb/tb_pwm_tx_sr.sv
// tb_pwm_tx_sr
//   Drives pwm_tx_sr through soft start, ramp, shadow updates, dead-time
//   windows, enable drop, reset and fault handling. A period-level reference
//   model predicts each period's OFF length, secondary window and ramp_done;
//   a monitor measures every period the DUT produces and compares.
module tb_pwm_tx_sr;
  localparam int CW        = 16;
  localparam int ON_DIV    = 20;
  localparam int START_OFF = 100;
  localparam int RAMP      = 10;

  typedef struct {
    int offLen;
    int secFirst;
    int secCnt;
    int rampDone;
  } expRec_t;

  logic clk;
  logic n_rst;
  pwm_tx_sr_if #(.CNT_WIDTH(CW)) bus ();

  pwm_tx_sr #(
    .CNT_WIDTH(CW), .ON_DIV(ON_DIV), .START_OFF_DIV(START_OFF), .RAMP_STEP(RAMP)
  ) dut (
    .clk(clk),
    .n_rst(n_rst),
    .bus(bus)
  );

  int testsRun = 0;
  int failCount = 0;
  expRec_t expQ[$];
  bit monEn = 0;

  int mOffEff, mActOff, mActPre, mActPost, mPendOff, mPendPre, mPendPost;
  bit mPendValid;
  int lastL;
  int chgOff[3], chgPre[3], chgPost[3];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #800000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int actual, input int required);
    testsRun++;
    if (actual != required) begin
      failCount++;
      $display("[TB] FAIL %s: got %0d, required %0d", name, actual, required);
    end
  endtask

  // Reference model: one call per period boundary, expressed in terms of
  // the off-time rules rather than cycles.
  function automatic void modelReset();
    mOffEff = START_OFF;
    mActOff = 0; mActPre = 0; mActPost = 0;
    mPendOff = 0; mPendPre = 0; mPendPost = 0;
    mPendValid = 0;
    lastL = START_OFF;
  endfunction

  function automatic void modelChg(input int idx);
    mPendOff = chgOff[idx]; mPendPre = chgPre[idx]; mPendPost = chgPost[idx];
    mPendValid = 1;
  endfunction

  function automatic void modelBoundary(input bit fromIdle, input bit act);
    expRec_t r;
    int gap;
    if (mPendValid) begin
      mActOff = mPendOff; mActPre = mPendPre; mActPost = mPendPost;
      mPendValid = 0;
    end
    if (fromIdle || act) mOffEff = START_OFF;
    else if (mOffEff > mActOff) begin
      gap = mOffEff - mActOff;
      mOffEff = mOffEff - ((gap > RAMP) ? RAMP : gap);
    end else mOffEff = mActOff;
    r.offLen   = (mOffEff == 0) ? 1 : mOffEff;
    r.secFirst = mActPre;
    r.secCnt   = (mActPre + mActPost < mOffEff) ? (mOffEff - mActPre - mActPost) : 0;
    r.rampDone = ((mOffEff == mActOff) && !act) ? 1 : 0;
    expQ.push_back(r);
    lastL = r.offLen;
  endfunction

  task automatic driveChg(input int idx);
    bus.off_div    = CW'(chgOff[idx]);
    bus.pre_delay  = CW'(chgPre[idx]);
    bus.post_delay = CW'(chgPost[idx]);
    bus.pwm_chg    = 1'b1;
  endtask

  task automatic setChg(input int idx, input int o, input int p, input int q);
    chgOff[idx] = o; chgPre[idx] = p; chgPost[idx] = q;
  endtask

  // One period of stimulus: wait for its first ON cycle, optionally capture
  // new timing at ON cycle 10 (one or two pulses), set act_ctl for the next
  // boundary, predict that boundary, and optionally pulse pwm_chg exactly on
  // the boundary edge.
  task automatic applyStimulus(input int nChg, input bit actNext, input bit bChg,
                               input bit doBoundary);
    int n, e, curL;
    n = 0;
    while (!bus.period_start && n < 400) begin
      @(negedge clk);
      n++;
    end
    checkOutput("period_start within budget", int'(bus.period_start), 1);
    if (!bus.period_start) return;
    curL = lastL;
    e = 0;
    repeat (10) begin
      @(negedge clk);
      e++;
    end
    for (int i = 0; i < nChg; i++) begin
      driveChg(i);
      @(negedge clk);
      e++;
      modelChg(i);
    end
    bus.pwm_chg = 1'b0;
    bus.act_ctl = actNext;
    if (doBoundary) modelBoundary(1'b0, actNext);
    if (bChg && doBoundary) begin
      while (e < ON_DIV + curL - 1) begin
        @(negedge clk);
        e++;
      end
      driveChg(2);
      @(negedge clk);
      bus.pwm_chg = 1'b0;
      modelChg(2);
    end
  endtask

  // Monitor: measures each period between period_start pulses and compares
  // against the record popped when that period began.
  initial begin : monitor
    expRec_t cur;
    bit hasCur, overlap;
    int onCnt, offCnt, secCnt, secFirst;
    hasCur = 0;
    overlap = 0;
    onCnt = 0; offCnt = 0; secCnt = 0; secFirst = 0;
    forever begin
      @(negedge clk);
      if (!monEn || !n_rst) begin
        hasCur = 0;
        continue;
      end
      if (bus.period_start) begin
        if (hasCur) begin
          checkOutput("on length", onCnt, ON_DIV);
          checkOutput("off length", offCnt, cur.offLen);
          checkOutput("secondary cycles", secCnt, cur.secCnt);
          if (cur.secCnt > 0) checkOutput("secondary first OFF cycle", secFirst, cur.secFirst);
          checkOutput("primary/secondary overlap", int'(overlap), 0);
        end
        checkOutput("period expected", int'(expQ.size() != 0), 1);
        if (expQ.size() != 0) begin
          cur = expQ.pop_front();
          hasCur = 1;
          checkOutput("ramp_done", int'(bus.ramp_done), cur.rampDone);
        end else hasCur = 0;
        onCnt = 0; offCnt = 0; secCnt = 0; secFirst = 0; overlap = 0;
      end
      if (hasCur) begin
        if (bus.pwm_out && bus.secondary_out) overlap = 1;
        if (bus.secondary_out) begin
          if (secCnt == 0) secFirst = offCnt;
          secCnt++;
        end
        if (bus.pwm_out) onCnt++;
        else offCnt++;
      end
    end
  end

  initial begin : stimulus
    int n;
    n_rst = 1'b0;
    bus.enable = 1'b0; bus.pwm_chg = 1'b0; bus.act_ctl = 1'b0;
    bus.off_div = '0; bus.pre_delay = '0; bus.post_delay = '0;
    bus.fault = 1'b0; bus.fault_clr = 1'b0;
    modelReset();
    repeat (3) @(negedge clk);
    checkOutput("reset pwm_out", int'(bus.pwm_out), 0);
    checkOutput("reset secondary_out", int'(bus.secondary_out), 0);
    checkOutput("reset period_start", int'(bus.period_start), 0);
    checkOutput("reset fault_flag", int'(bus.fault_flag), 0);
    checkOutput("reset ramp_done", int'(bus.ramp_done), 0);

    // Async reset in the middle of ON.
    n_rst = 1'b1;
    bus.act_ctl = 1'b1;
    bus.enable = 1'b1;
    n = 0;
    while (!bus.period_start && n < 50) begin
      @(negedge clk);
      n++;
    end
    repeat (5) @(negedge clk);
    checkOutput("pwm_out high mid-ON", int'(bus.pwm_out), 1);
    #2 n_rst = 1'b0;
    #1;
    checkOutput("async reset pwm_out", int'(bus.pwm_out), 0);
    checkOutput("async reset secondary_out", int'(bus.secondary_out), 0);
    bus.enable = 1'b0;
    @(negedge clk);
    n_rst = 1'b1;
    repeat (3) @(negedge clk);
    checkOutput("idle after reset pwm_out", int'(bus.pwm_out), 0);
    checkOutput("idle after reset period_start", int'(bus.period_start), 0);
    modelReset();

    // Soft start with 40/5/5 pending, then ramp down to 40.
    setChg(0, 40, 5, 5);
    driveChg(0);
    @(negedge clk);
    bus.pwm_chg = 1'b0;
    modelChg(0);
    modelBoundary(1'b1, 1'b1);
    monEn = 1;
    bus.enable = 1'b1;
    applyStimulus(0, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1);

    // Longer off-time mid-period, then two captures in one period.
    setChg(0, 60, 5, 5);
    applyStimulus(1, 1'b0, 1'b0, 1'b1);
    setChg(0, 40, 5, 5);
    setChg(1, 40, 25, 20);
    applyStimulus(2, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b1);

    // Randomised periods.
    for (int p = 0; p < 25; p++) begin
      int nc;
      bit ac, bc;
      nc = int'($urandom_range(0, 2));
      for (int i = 0; i < 3; i++)
        setChg(i, int'($urandom_range(0, 70)), int'($urandom_range(0, 30)),
               int'($urandom_range(0, 30)));
      ac = ($urandom_range(0, 7) == 0);
      bc = ($urandom_range(0, 5) == 0);
      applyStimulus(nc, ac, bc, 1'b1);
    end

    // Drop enable mid-ON, then restart from IDLE.
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    monEn = 0;
    bus.enable = 1'b0;
    @(negedge clk);
    checkOutput("enable drop pwm_out", int'(bus.pwm_out), 0);
    checkOutput("enable drop secondary_out", int'(bus.secondary_out), 0);
    repeat (3) @(negedge clk);
    modelBoundary(1'b1, bus.act_ctl);
    monEn = 1;
    bus.enable = 1'b1;
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1);

    // Fault at OFF cycle 12 of a 100-cycle OFF with a 5/5 dead time.
    setChg(0, 40, 5, 5);
    applyStimulus(1, 1'b1, 1'b0, 1'b1);
    applyStimulus(0, 1'b1, 1'b0, 1'b0);
    monEn = 0;
    repeat (22) @(negedge clk);
    checkOutput("pre-fault pwm_out", int'(bus.pwm_out), 0);
    checkOutput("pre-fault secondary_out", int'(bus.secondary_out), 1);
    bus.fault = 1'b1;
    @(negedge clk);
    checkOutput("fault pwm_out", int'(bus.pwm_out), 0);
    checkOutput("fault secondary_out", int'(bus.secondary_out), 0);
    checkOutput("fault_flag set", int'(bus.fault_flag), 1);
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    checkOutput("fault_clr ignored while fault", int'(bus.fault_flag), 1);
    bus.fault = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("fault held without clear", int'(bus.fault_flag), 1);
    bus.act_ctl = 1'b0;
    modelBoundary(1'b1, 1'b0);
    monEn = 1;
    bus.fault_clr = 1'b1;
    @(negedge clk);
    bus.fault_clr = 1'b0;
    checkOutput("fault cleared", int'(bus.fault_flag), 0);
    for (int i = 0; i < 3; i++) applyStimulus(0, 1'b0, 1'b0, 1'b1);
    applyStimulus(0, 1'b0, 1'b0, 1'b0);
    monEn = 0;
    @(negedge clk);
    checkOutput("scoreboard drained", expQ.size(), 0);

    $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
    $finish;
  end
endmodule

// File: doc/pwm_tx_sr.md
Name: pwm_tx_sr

Overview:
- Next-generation primary PWM transmitter with a synchronous-rectifier secondary output.
- Generalises the fixed-on-time PWM generator with:
  - a real dead-time-windowed secondary drive;
  - period-boundary shadow updates;
  - a soft-start ramp of off-time;
  - an enable/fault shutdown path.
- Sits between the PID controller (supplies off_div and delays) and the gate-drive pins.

Parameters:
- CNT_WIDTH, 16: width of all counters and timing inputs.
- ON_DIV, 20: fixed ON-phase length in clk cycles (≥1).
- START_OFF_DIV, 100: off-time used during act_ctl and at every start-up.
- RAMP_STEP, 10: maximum off-time decrease per period while ramping (≥1).

Ports:
- clk  in  1  system clock
- n_rst  in  1  asynchronous active-low reset
- enable  in  1  level; 0 forces IDLE
- pwm_chg  in  1  pulse; capture off_div/pre_delay/post_delay into the pending set
- act_ctl  in  1  level; hold off-time at START_OFF_DIV
- off_div  in  CNT_WIDTH  commanded OFF-phase length
- pre_delay  in  CNT_WIDTH  OFF-phase cycles before secondary turns on
- post_delay  in  CNT_WIDTH  OFF-phase cycles secondary is off before the next ON
- fault  in  1  level, synchronous; kills outputs
- fault_clr  in  1  pulse; leave FAULT
- pwm_out  out  1  primary gate
- secondary_out  out  1  synchronous-rectifier gate
- period_start  out  1  one-cycle pulse on the first ON cycle of each period
- ramp_done  out  1  off_eff == off_act and act_ctl == 0
- fault_flag  out  1  high while in FAULT

Behaviour:
- Reset (async, n_rst=0):
  - state IDLE; all outputs 0.
  - off_eff = START_OFF_DIV.
  - Active and pending sets = 0; pending_valid = 0.
- Outputs: all registered. pwm_out = 1 only in ON; secondary_out only in OFF. Never both high.
- States: IDLE, ON, OFF, FAULT. Priority per edge: fault > !enable > normal sequencing.
- FAULT:
  - Entry: from any state when fault=1; outputs 0 from the next cycle.
  - Exit: leave to IDLE on an edge with fault_clr=1 and fault=0. fault_clr while fault=1 is ignored.
- IDLE:
  - enable=0 from ON/OFF: next state IDLE; outputs 0 from the next cycle; no phase completion.
  - IDLE -> ON when enable=1 and fault=0.
  - Every exit from IDLE loads off_eff = START_OFF_DIV, so soft start always restarts.
- ON:
  - Lasts exactly ON_DIV cycles (counter 0..ON_DIV-1), then OFF.
- OFF:
  - Lasts off_eff cycles (counter k = 0..off_eff-1), then ON.
  - off_eff = 0 is treated as 1.
- Period boundary (each edge entering ON, including from IDLE):
  - period_start = 1 for that first ON cycle.
  - If pending_valid: active set <= pending set; pending_valid <= 0.
  - off_eff update, in order of precedence:
    - act_ctl=1: off_eff <= START_OFF_DIV.
    - off_eff > off_act: off_eff <= off_eff - min(RAMP_STEP, off_eff - off_act).
    - Otherwise: off_eff <= off_act, applied immediately; a longer off-time is the safe direction.
  - Uses the off_act value just loaded in the same edge.
- pwm_chg:
  - Overwrites the pending set at any time; the latest capture wins.
  - Never alters the period in progress.
  - pwm_chg on the same edge as a period boundary is applied at the following boundary.
- Secondary window:
  - secondary_out = 1 on OFF cycle k iff pre_act ≤ k < off_eff - post_act.
  - Compute in CNT_WIDTH+1 bits. If pre_act + post_act ≥ off_eff, secondary stays 0 for the whole period.
- Counter: resets to 0 on every state change; never wraps. All limits are compared as unsigned.

Test Plan:
Defaults ON_DIV=20, START_OFF_DIV=100, RAMP_STEP=10.
1. Reset:
   - n_rst low mid-ON -> pwm_out and secondary_out are 0 immediately; after release with enable=0, state IDLE and outputs 0.
2. Soft start:
   - enable=1, act_ctl=1 -> pwm_out high 20 cycles, low 100 cycles; period_start every 120 cycles; ramp_done=0.
3. Ramp:
   - pwm_chg with off_div=40, then act_ctl=0 -> successive OFF lengths 100,90,80,70,60,50,40,40…; ramp_done=1 from the period with off_eff=40.
4. Dead-time:
   - off=40, pre=5, post=5 -> secondary high on OFF cycles 5..34 (30 cycles).
   - pre=25, post=20 -> secondary never high.
   - Throughout: pwm_out & secondary_out never both 1.
5. Shadow update:
   - pwm_chg off_div=60 at ON cycle 10 during steady off=40 -> current OFF still 40; next OFF 60 (increase immediate).
   - Two pwm_chg pulses in one period -> only the second is applied.
6. Fault:
   - fault=1 at OFF cycle 12 -> both outputs 0 next cycle; fault_flag=1.
   - fault_clr with fault=1 is ignored.
   - fault=0 then fault_clr -> IDLE -> ON; first OFF length is 100.
